pq_arb: RTL and testbench

- Shares one priority queue instance (ra_pq_s-class device, dev-side signals) between NCLIENT independent requesters.
- Each client posts enqueue or dequeue requests. pq_arb selects one client round-robin, sequences the single-cycle enq/deq strobe into the queue, and waits out queue busy.
- On completion it returns a grant pulse, plus the dequeued key/value for dequeues.
- Sits between client logic and the queue in the HWPQ study top levels.

---
 rtl/pq_pkg.sv | 21 ++
 rtl/rr_pick.sv | 29 ++
 rtl/pq_arb.sv | 136 +++++++++++++
 tb/tb_pq_arb.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// Shared types for the priority-queue arbiter: key/value record, arbiter FSM states,
// statistics counter width.
package pq_pkg;

    localparam int unsigned KEY_W      = 16;
    localparam int unsigned VAL_W      = 16;
    localparam int unsigned ARB_STAT_W = 16;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] value;
    } kv_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first pending index at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned NCLIENT = 4,
    parameter int unsigned IDW     = (NCLIENT > 1) ? $clog2(NCLIENT) : 1
) (
    input  logic [NCLIENT-1:0] pending,
    input  logic [IDW-1:0]     ptr,
    output logic [NCLIENT-1:0] grant,
    output logic [IDW-1:0]     id,
    output logic               any
);

    always_comb begin : pick
        int unsigned idx;
        grant = '0;
        id    = '0;
        any   = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NCLIENT; k++) begin
            idx = (32'(ptr) + k) % NCLIENT;
            if (!any && pending[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                id         = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/pq_arb.sv
// Round-robin arbiter sharing one priority queue between NCLIENT requesters.
// Optional per-client statistics counters when PQ_ARB_STATS_EN is defined.
module pq_arb
    import pq_pkg::*;
#(
    parameter int unsigned NCLIENT = 4,
    parameter int unsigned KW      = KEY_W,
    parameter int unsigned VW      = VAL_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NCLIENT-1:0]         req_enq,
    input  logic [NCLIENT-1:0]         req_deq,
    input  logic [NCLIENT*(KW+VW)-1:0] req_kv,
    output logic [NCLIENT-1:0]         gnt,
    output logic                       rsp_err,
    output logic [KW+VW-1:0]           rsp_kv,
    output logic                       pq_enq,
    output logic                       pq_deq,
    output logic [KW+VW-1:0]           pq_kvi_in,
    input  logic [KW+VW-1:0]           pq_kvi_out,
    input  logic                       pq_full,
    input  logic                       pq_empty,
    input  logic                       pq_busy
`ifdef PQ_ARB_STATS_EN
    ,
    output logic [NCLIENT*ARB_STAT_W-1:0] grant_cnt,
    output logic [ARB_STAT_W-1:0]         err_cnt
`endif
);

    localparam int unsigned KVW = KW + VW;
    localparam int unsigned IDW = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;

    arb_state_t          state, state_nxt;
    logic [IDW-1:0]      rr_ptr, id_q, pick_id;
    logic [NCLIENT-1:0]  pending, pick_oh, gnt_nxt;
    logic                pick_any, sel, sel_deq, sel_refuse;
    logic                err_q, enq_nxt, deq_nxt, err_nxt, done_nxt;

    assign pending = req_enq | req_deq;

    rr_pick #(
        .NCLIENT(NCLIENT),
        .IDW    (IDW)
    ) u_pick (
        .pending(pending),
        .ptr    (rr_ptr),
        .grant  (pick_oh),
        .id     (pick_id),
        .any    (pick_any)
    );

    assign sel_deq    = |(req_deq & pick_oh);
    assign sel_refuse = sel_deq ? pq_empty : pq_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Full/empty is resolved in the selecting cycle so the ISSUE strobe can come
    // straight from a flop; only this arbiter changes the queue in between.
    always_comb begin
        state_nxt = state;
        sel       = 1'b0;
        enq_nxt   = 1'b0;
        deq_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any && !pq_busy) begin
                    state_nxt = ISSUE;
                    sel       = 1'b1;
                    enq_nxt   = !sel_deq && !pq_full;
                    deq_nxt   = sel_deq && !pq_empty;
                end
            end
            ISSUE:   state_nxt = err_q ? DONE : WAIT;
            WAIT:    if (!pq_busy) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        done_nxt = (state_nxt == DONE) && (state != DONE);
        gnt_nxt  = done_nxt ? (NCLIENT'(1) << id_q) : '0;
        err_nxt  = done_nxt && err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            id_q      <= '0;
            err_q     <= 1'b0;
            pq_enq    <= 1'b0;
            pq_deq    <= 1'b0;
            pq_kvi_in <= '0;
            rsp_kv    <= '0;
            gnt       <= '0;
            rsp_err   <= 1'b0;
        end else begin
            pq_enq  <= enq_nxt;
            pq_deq  <= deq_nxt;
            gnt     <= gnt_nxt;
            rsp_err <= err_nxt;
            if (sel) begin
                id_q      <= pick_id;
                err_q     <= sel_refuse;
                pq_kvi_in <= req_kv[int'(pick_id)*KVW +: KVW];
            end
            if (pq_deq) rsp_kv <= pq_kvi_out;
            if (state == DONE) begin
                rr_ptr <= (id_q == IDW'(NCLIENT-1)) ? '0 : id_q + 1'b1;
                err_q  <= 1'b0;
            end
        end
    end

`ifdef PQ_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
            err_cnt   <= '0;
        end else if (state == DONE) begin
            if (err_q) begin
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end else begin
                for (int unsigned i = 0; i < NCLIENT; i++) begin
                    if (id_q == IDW'(i) && grant_cnt[i*ARB_STAT_W +: ARB_STAT_W] != '1)
                        grant_cnt[i*ARB_STAT_W +: ARB_STAT_W] <=
                            grant_cnt[i*ARB_STAT_W +: ARB_STAT_W] + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_pq_arb.sv
// Bench for pq_arb: a stand-in min-first queue device plus a queue/round-robin
// reference model; PQ_ARB_STATS_EN only adds the counter port connections.
module tb_pq_arb;

    localparam int N   = 4;
    localparam int KW  = 16;
    localparam int VW  = 16;
    localparam int KVW = KW + VW;
    localparam int CAP = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0]     req_enq = '0;
    logic [N-1:0]     req_deq = '0;
    logic [N*KVW-1:0] req_kv  = '0;
    logic [N-1:0]     gnt;
    logic             rsp_err;
    logic [KVW-1:0]   rsp_kv;
    logic             pq_enq, pq_deq;
    logic [KVW-1:0]   pq_kvi_in;
    logic [KVW-1:0]   pq_kvi_out = '0;
    logic             pq_full  = 1'b0;
    logic             pq_empty = 1'b1;
    logic             pq_busy  = 1'b0;
`ifdef PQ_ARB_STATS_EN
    logic [N*16-1:0]  grant_cnt;
    logic [15:0]      err_cnt;
`endif

    always #5 clk = ~clk;

    pq_arb #(.NCLIENT(N), .KW(KW), .VW(VW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_enq   (req_enq),
        .req_deq   (req_deq),
        .req_kv    (req_kv),
        .gnt       (gnt),
        .rsp_err   (rsp_err),
        .rsp_kv    (rsp_kv),
        .pq_enq    (pq_enq),
        .pq_deq    (pq_deq),
        .pq_kvi_in (pq_kvi_in),
        .pq_kvi_out(pq_kvi_out),
        .pq_full   (pq_full),
        .pq_empty  (pq_empty),
        .pq_busy   (pq_busy)
`ifdef PQ_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt),
        .err_cnt   (err_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Queue device stand-in: sorted storage, min at head, busy for busy_extra cycles after a strobe.
    logic [KVW-1:0] dq[$];
    logic [KVW-1:0] last_enq = '0;
    logic flush = 1'b0;
    int busy_extra = 0, busy_left = 0;
    int enq_strobes = 0, deq_strobes = 0, both_viol = 0, busy_viol = 0;

    // Reference model of queue contents and round-robin pointer.
    logic [KVW-1:0] model[$];
    int model_ptr = 0;

    function automatic int ins_pos(input logic [KVW-1:0] q[$], input logic [KVW-1:0] v);
        for (int i = 0; i < q.size(); i++)
            if (q[i] > v) return i;
        return q.size();
    endfunction

    function automatic int rr_expect(input logic [N-1:0] pend, input int ptr);
        for (int k = 0; k < N; k++)
            if (pend[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (flush) begin
            dq.delete();
            busy_left = 0;
        end else begin
            if (pq_enq && pq_deq) both_viol++;
            if ((pq_enq || pq_deq) && pq_busy) busy_viol++;
            if (pq_deq) begin
                deq_strobes++;
                if (dq.size() > 0) void'(dq.pop_front());
            end
            if (pq_enq) begin
                enq_strobes++;
                dq.insert(ins_pos(dq, pq_kvi_in), pq_kvi_in);
                last_enq = pq_kvi_in;
            end
            if (pq_enq || pq_deq) busy_left = busy_extra;
            else if (busy_left > 0) busy_left--;
        end
        pq_kvi_out <= (dq.size() > 0) ? dq[0] : '0;
        pq_full    <= (dq.size() >= CAP);
        pq_empty   <= (dq.size() == 0);
        pq_busy    <= (busy_left > 0);
    end

    task automatic do_flush();
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        model.delete();
    endtask

    task automatic wait_gnt(output logic [N-1:0] g, output int lat);
        g = '0;
        lat = 0;
        while (g == '0 && lat < 60) begin
            @(negedge clk);
            lat++;
            g = gnt;
        end
    endtask

    task automatic run_single(input int id, input bit deq, input logic [KVW-1:0] kv,
                              output int lat, output logic err, output logic [KVW-1:0] kvo,
                              output logic [N-1:0] g);
        @(posedge clk); #1;
        req_kv[id*KVW +: KVW] = kv;
        if (deq) req_deq[id] = 1'b1;
        else     req_enq[id] = 1'b1;
        wait_gnt(g, lat);
        err = rsp_err;
        kvo = rsp_kv;
        @(posedge clk); #1;
        req_deq[id] = 1'b0;
        req_enq[id] = 1'b0;
        model_ptr = (id + 1) % N;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({gnt, rsp_err, pq_enq, pq_deq, rsp_kv, pq_kvi_in} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got gnt=%b err=%b enq=%b deq=%b kv=%h kvi=%h want all 0",
                     gnt, rsp_err, pq_enq, pq_deq, rsp_kv, pq_kvi_in);
        end
        rst_n = 1'b1;
        model_ptr = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({gnt, pq_enq, pq_deq} !== '0) begin
            failures++;
            $display("FAIL idle_after_reset: got gnt=%b enq=%b deq=%b want 0", gnt, pq_enq, pq_deq);
        end
    endtask

    task automatic test_round_robin();
        int keys[4] = '{9, 3, 7, 1};
        int dkeys[4] = '{1, 3, 7, 9};
        logic [N-1:0] g;
        logic [KVW-1:0] kvo;
        logic err;
        int lat;
        do_flush();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            req_kv[i*KVW +: KVW] = {16'(keys[i]), 16'(i + 100)};
            req_enq[i] = 1'b1;
        end
        for (int s = 0; s < N; s++) begin
            wait_gnt(g, lat);
            checks++;
            if (g !== 4'(1 << s) || rsp_err !== 1'b0) begin
                failures++;
                $display("FAIL rr_order[%0d]: got gnt=%b err=%b want gnt=%b err=0", s, g, rsp_err, 4'(1 << s));
            end
            @(posedge clk); #1;
            req_enq = '0 | (req_enq & ~(4'(1 << s)));
            model_ptr = (s + 1) % N;
        end
        for (int j = 0; j < N; j++) begin
            run_single(j, 1'b1, '0, lat, err, kvo, g);
            checks++;
            if (g !== 4'(1 << j) || err !== 1'b0 || kvo[31:16] !== 16'(dkeys[j])) begin
                failures++;
                $display("FAIL min_first_deq[%0d]: got gnt=%b err=%b key=%0d want gnt=%b err=0 key=%0d",
                         j, g, err, kvo[31:16], 4'(1 << j), dkeys[j]);
            end
        end
    endtask

    task automatic test_single_enq();
        logic [N-1:0] g;
        logic [KVW-1:0] kvo;
        logic err;
        int lat, s;
        do_flush();
        s = enq_strobes;
        run_single(0, 1'b0, {16'd5, 16'hABCD}, lat, err, kvo, g);
        checks++;
        if (g !== 4'b0001 || lat !== 4 || err !== 1'b0) begin
            failures++;
            $display("FAIL single_enq: got gnt=%b lat=%0d err=%b want gnt=0001 lat=4 err=0", g, lat, err);
        end
        checks++;
        if (enq_strobes - s !== 1 || last_enq !== {16'd5, 16'hABCD}) begin
            failures++;
            $display("FAIL single_enq_strobe: got strobes=%0d data=%h want 1 data=0005abcd",
                     enq_strobes - s, last_enq);
        end
    endtask

    task automatic test_empty_deq();
        logic [N-1:0] g;
        logic [KVW-1:0] kvo;
        logic err;
        int lat, s;
        do_flush();
        s = deq_strobes;
        run_single(2, 1'b1, '0, lat, err, kvo, g);
        checks++;
        if (g !== 4'b0100 || err !== 1'b1 || lat !== 3) begin
            failures++;
            $display("FAIL empty_deq: got gnt=%b err=%b lat=%0d want gnt=0100 err=1 lat=3", g, err, lat);
        end
        checks++;
        if (deq_strobes !== s) begin
            failures++;
            $display("FAIL empty_deq_strobe: got %0d strobes want 0", deq_strobes - s);
        end
    endtask

    task automatic test_full();
        logic [N-1:0] g;
        logic [KVW-1:0] kvo;
        logic err;
        int lat, s;
        do_flush();
        for (int k = 0; k < CAP; k++) begin
            run_single(k % N, 1'b0, {16'(100 - 7 * k), 16'(k)}, lat, err, kvo, g);
            checks++;
            if (err !== 1'b0) begin
                failures++;
                $display("FAIL fill_enq[%0d]: got err=%b want 0", k, err);
            end
        end
        s = enq_strobes;
        run_single(1, 1'b0, {16'd1, 16'd1}, lat, err, kvo, g);
        checks++;
        if (g !== 4'b0010 || err !== 1'b1 || enq_strobes !== s) begin
            failures++;
            $display("FAIL full_enq: got gnt=%b err=%b strobes=%0d want gnt=0010 err=1 strobes=0",
                     g, err, enq_strobes - s);
        end
        @(posedge clk); #1;
        req_deq[0] = 1'b1;
        req_deq[3] = 1'b1;
        wait_gnt(g, lat);
        checks++;
        if (g !== 4'b1000 || rsp_err !== 1'b0 || rsp_kv[31:16] !== 16'd51) begin
            failures++;
            $display("FAIL full_then_deq3: got gnt=%b err=%b key=%0d want gnt=1000 err=0 key=51",
                     g, rsp_err, rsp_kv[31:16]);
        end
        @(posedge clk); #1 req_deq[3] = 1'b0;
        wait_gnt(g, lat);
        checks++;
        if (g !== 4'b0001 || rsp_err !== 1'b0 || rsp_kv[31:16] !== 16'd58) begin
            failures++;
            $display("FAIL full_then_deq0: got gnt=%b err=%b key=%0d want gnt=0001 err=0 key=58",
                     g, rsp_err, rsp_kv[31:16]);
        end
        @(posedge clk); #1 req_deq[0] = 1'b0;
        model_ptr = 1;
    endtask

    task automatic test_busy();
        logic [N-1:0] g;
        logic [KVW-1:0] kvo;
        logic err;
        int lat, s;
        do_flush();
        busy_extra = 5;
        s = enq_strobes;
        run_single(1, 1'b0, {16'd42, 16'd0}, lat, err, kvo, g);
        busy_extra = 0;
        checks++;
        if (g !== 4'b0010 || lat !== 9 || err !== 1'b0) begin
            failures++;
            $display("FAIL busy_latency: got gnt=%b lat=%0d err=%b want gnt=0010 lat=9 err=0", g, lat, err);
        end
        checks++;
        if (enq_strobes - s !== 1) begin
            failures++;
            $display("FAIL busy_single_strobe: got %0d strobes want 1", enq_strobes - s);
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] g;
        int lat;
        do_flush();
        busy_extra = 10;
        @(posedge clk); #1;
        req_kv[2*KVW +: KVW] = {16'd77, 16'd0};
        req_enq[2] = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, rsp_err, pq_enq, pq_deq, rsp_kv, pq_kvi_in} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got gnt=%b err=%b enq=%b deq=%b kv=%h kvi=%h want all 0",
                     gnt, rsp_err, pq_enq, pq_deq, rsp_kv, pq_kvi_in);
        end
        req_enq = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (gnt !== '0) begin
                failures++;
                $display("FAIL reset_mid_no_gnt[%0d]: got gnt=%b want 0000", c, gnt);
            end
        end
        rst_n = 1'b1;
        model_ptr = 0;
        busy_extra = 0;
        repeat (12) @(posedge clk);
        do_flush();
        @(posedge clk); #1;
        req_kv[0 +: KVW] = {16'd4, 16'd0};
        req_kv[2*KVW +: KVW] = {16'd6, 16'd0};
        req_enq[0] = 1'b1;
        req_enq[2] = 1'b1;
        wait_gnt(g, lat);
        checks++;
        if (g !== 4'b0001) begin
            failures++;
            $display("FAIL after_reset_first: got gnt=%b want 0001", g);
        end
        @(posedge clk); #1 req_enq[0] = 1'b0;
        wait_gnt(g, lat);
        checks++;
        if (g !== 4'b0100) begin
            failures++;
            $display("FAIL after_reset_second: got gnt=%b want 0100", g);
        end
        @(posedge clk); #1 req_enq[2] = 1'b0;
        model_ptr = 3;
    endtask

    task automatic test_random();
        logic [N-1:0] g;
        logic [KVW-1:0] kv;
        logic exp_err, is_deq;
        int lat, exp_id, guard;
        do_flush();
        for (int r = 0; r < 30; r++) begin
            @(posedge clk); #1;
            busy_extra = $urandom_range(0, 3);
            for (int i = 0; i < N; i++) begin
                int op;
                op = $urandom_range(0, 5);
                req_kv[i*KVW +: KVW] = {16'($urandom), 16'($urandom)};
                req_enq[i] = (op == 2 || op == 3 || op == 5);
                req_deq[i] = (op == 4 || op == 5);
            end
            guard = 0;
            while ((req_enq | req_deq) != '0 && guard < 20) begin
                guard++;
                exp_id = rr_expect(req_enq | req_deq, model_ptr);
                is_deq = req_deq[exp_id];
                exp_err = is_deq ? (model.size() == 0) : (model.size() >= CAP);
                wait_gnt(g, lat);
                checks++;
                if (g !== 4'(1 << exp_id) || rsp_err !== exp_err) begin
                    failures++;
                    $display("FAIL rand_grant r%0d: got gnt=%b err=%b want gnt=%b err=%b",
                             r, g, rsp_err, 4'(1 << exp_id), exp_err);
                    if (g == '0) begin
                        req_enq = '0;
                        req_deq = '0;
                        break;
                    end
                end
                if (is_deq && !exp_err) begin
                    checks++;
                    if (rsp_kv !== model[0]) begin
                        failures++;
                        $display("FAIL rand_deq_kv r%0d: got %h want %h", r, rsp_kv, model[0]);
                    end
                    void'(model.pop_front());
                end else if (!is_deq && !exp_err) begin
                    kv = req_kv[exp_id*KVW +: KVW];
                    model.insert(ins_pos(model, kv), kv);
                end
                model_ptr = (exp_id + 1) % N;
                @(posedge clk); #1;
                if (is_deq) req_deq[exp_id] = 1'b0;
                else        req_enq[exp_id] = 1'b0;
            end
        end
        busy_extra = 0;
    endtask

    task automatic test_protocol();
        repeat (6) @(posedge clk);
        checks++;
        if (both_viol !== 0 || busy_viol !== 0) begin
            failures++;
            $display("FAIL strobe_protocol: got both=%0d during_busy=%0d want 0 0", both_viol, busy_viol);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_enq();
        test_empty_deq();
        test_full();
        test_busy();
        test_reset_mid();
        test_random();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
